vend_sequencer: RTL and testbench

VEND_SEQUENCER -- requirements
Module: vend_sequencer

---
 rtl/vend_sequencer.sv | 164 ++++++++++++++++
 tb/tb_vend_sequencer.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vend_sequencer.sv
// Coin-operated vend sequencer: accumulates credit, requests a vend, then pays change one nickel at a time.
// Optional idle auto-refund in CREDIT is built only when VEND_TIMEOUT_EN is defined.
//
// state     | meaning
// ----------+-----------------------------------------------
// ST_IDLE   | no credit, coins accepted
// ST_CREDIT | 0 < credit < PRICE_UNITS, coins accepted
// ST_VEND   | vend_req held until the dispenser acks
// ST_CHANGE | change_req held while nickels are still owed
`timescale 1ns/1ps

module vend_sequencer #(
    parameter int PRICE_UNITS    = 4,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_coin_valid,
    input  logic [1:0] i_coins,
    input  logic       i_cancel,
    input  logic       i_vend_ack,
    input  logic       i_change_ack,
    output logic       o_coin_ready,
    output logic       o_coin_reject,
    output logic       o_vend_req,
    output logic       o_change_req,
    output logic [3:0] o_credit,
    output logic [3:0] o_change_left,
    output logic       o_busy
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CREDIT = 2'd1,
        ST_VEND   = 2'd2,
        ST_CHANGE = 2'd3
    } state_t;

    localparam logic [3:0] LP_PRICE = 4'(PRICE_UNITS);

    state_t     r_state;
    state_t     w_state_nxt;
    logic [3:0] r_credit;
    logic [3:0] w_credit_nxt;
    logic [3:0] r_change_left;
    logic [3:0] w_change_left_nxt;
    logic       r_coin_reject;
    logic       w_coin_reject_nxt;
    logic       w_ready;
    logic       w_coin_ok;
    logic       w_cancel;
    logic       w_timeout;
    logic [3:0] w_coin_val;
    logic [3:0] w_sum;

    always_comb begin
        case (i_coins)
            2'b01:   w_coin_val = 4'd1;
            2'b10:   w_coin_val = 4'd2;
            2'b11:   w_coin_val = 4'd5;
            default: w_coin_val = 4'd0;
        endcase
    end

    assign w_ready   = (r_state == ST_IDLE) || (r_state == ST_CREDIT);
    assign w_coin_ok = i_coin_valid && w_ready && (i_coins != 2'b00);
    assign w_sum     = r_credit + w_coin_val;
    assign w_cancel  = i_cancel || w_timeout;

`ifdef VEND_TIMEOUT_EN
    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] LP_TC = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] r_tmo_cnt;

    assign w_timeout = (r_state == ST_CREDIT) && (r_tmo_cnt == LP_TC);

    // Counts only while staying in CREDIT with no new coin; cleared otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tmo_cnt <= '0;
        end else if ((r_state == ST_CREDIT) && (w_state_nxt == ST_CREDIT) && !w_coin_ok) begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
        end else begin
            r_tmo_cnt <= '0;
        end
    end
`else
    // Timeout length only matters when the auto-refund counter is built.
    assign w_timeout = 1'b0 && (TIMEOUT_CYCLES > 0);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_credit      <= 4'd0;
            r_change_left <= 4'd0;
            r_coin_reject <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_credit      <= w_credit_nxt;
            r_change_left <= w_change_left_nxt;
            r_coin_reject <= w_coin_reject_nxt;
        end
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_credit_nxt      = r_credit;
        w_change_left_nxt = r_change_left;
        w_coin_reject_nxt = i_coin_valid && !w_coin_ok;

        case (r_state)
            ST_IDLE, ST_CREDIT: begin
                if (w_coin_ok) begin
                    // A coin arriving with a cancel is refunded in full, never vended.
                    if (w_cancel) begin
                        w_change_left_nxt = w_sum;
                        w_credit_nxt      = 4'd0;
                        w_state_nxt       = ST_CHANGE;
                    end else if (w_sum >= LP_PRICE) begin
                        w_change_left_nxt = w_sum - LP_PRICE;
                        w_credit_nxt      = 4'd0;
                        w_state_nxt       = ST_VEND;
                    end else begin
                        w_credit_nxt      = w_sum;
                        w_state_nxt       = ST_CREDIT;
                    end
                end else if (w_cancel && (r_state == ST_CREDIT)) begin
                    w_change_left_nxt = r_credit;
                    w_credit_nxt      = 4'd0;
                    w_state_nxt       = ST_CHANGE;
                end
            end
            ST_VEND: begin
                if (i_vend_ack) begin
                    w_state_nxt = (r_change_left != 4'd0) ? ST_CHANGE : ST_IDLE;
                end
            end
            ST_CHANGE: begin
                if (r_change_left == 4'd0) begin
                    w_state_nxt = ST_IDLE;
                end else if (i_change_ack) begin
                    w_change_left_nxt = r_change_left - 4'd1;
                    if (r_change_left == 4'd1) begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign o_coin_ready  = w_ready;
    assign o_coin_reject = r_coin_reject;
    assign o_vend_req    = (r_state == ST_VEND);
    assign o_change_req  = (r_state == ST_CHANGE) && (r_change_left != 4'd0);
    assign o_credit      = r_credit;
    assign o_change_left = r_change_left;
    assign o_busy        = (r_state == ST_VEND) || (r_state == ST_CHANGE);

endmodule

// File: tb/tb_vend_sequencer.sv
// Bench for vend_sequencer: directed scenarios with literal expectations plus a randomized
// run, all cross-checked every cycle against a transaction-level model of the vending rules.
`timescale 1ns/1ps

module tb_vend_sequencer;

    localparam int P = 4;
    localparam int T = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       coin_valid = 1'b0;
    logic [1:0] coins = 2'b00;
    logic       cancel = 1'b0;
    logic       vend_ack = 1'b0;
    logic       change_ack = 1'b0;
    logic       coin_ready;
    logic       coin_reject;
    logic       vend_req;
    logic       change_req;
    logic [3:0] credit;
    logic [3:0] change_left;
    logic       busy;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    vend_sequencer #(.PRICE_UNITS(P), .TIMEOUT_CYCLES(T)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_coin_valid (coin_valid),
        .i_coins      (coins),
        .i_cancel     (cancel),
        .i_vend_ack   (vend_ack),
        .i_change_ack (change_ack),
        .o_coin_ready (coin_ready),
        .o_coin_reject(coin_reject),
        .o_vend_req   (vend_req),
        .o_change_req (change_req),
        .o_credit     (credit),
        .o_change_left(change_left),
        .o_busy       (busy)
    );

    // Model: a pending vend, a pending refund of m_owed nickels, and accumulated credit.
    bit m_vending, m_refunding, m_rej;
    int m_credit, m_owed, m_idle;
    bit m_rdy, m_acc, m_was_cr, m_canc;
    int m_val, m_sum;

    function automatic int coin_units(input logic [1:0] c);
        case (c)
            2'b01:   return 1;
            2'b10:   return 2;
            2'b11:   return 5;
            default: return 0;
        endcase
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_vending = 0; m_refunding = 0; m_rej = 0;
            m_credit = 0; m_owed = 0; m_idle = 0;
        end else begin
            m_rdy    = !m_vending && !m_refunding;
            m_val    = coin_units(coins);
            m_acc    = coin_valid && m_rdy && (m_val > 0);
            m_rej    = coin_valid && !m_acc;
            m_was_cr = m_rdy && (m_credit > 0);
            m_canc   = cancel;
`ifdef VEND_TIMEOUT_EN
            if (m_was_cr && (m_idle == T - 1)) m_canc = 1;
`endif
            if (m_vending) begin
                if (vend_ack) begin
                    m_vending   = 0;
                    m_refunding = (m_owed > 0);
                end
            end else if (m_refunding) begin
                if (change_ack) begin
                    m_owed = m_owed - 1;
                    if (m_owed == 0) m_refunding = 0;
                end
            end else if (m_acc) begin
                m_sum    = m_credit + m_val;
                m_credit = 0;
                if (m_canc) begin
                    m_owed = m_sum; m_refunding = 1;
                end else if (m_sum >= P) begin
                    m_owed = m_sum - P; m_vending = 1;
                end else begin
                    m_credit = m_sum;
                end
            end else if (m_canc && (m_credit > 0)) begin
                m_owed = m_credit; m_credit = 0; m_refunding = 1;
            end
            m_idle = (m_was_cr && !m_acc && !m_vending && !m_refunding && (m_credit > 0)) ? m_idle + 1 : 0;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("model coin_ready",  int'(coin_ready),  int'(!m_vending && !m_refunding));
        chk("model coin_reject", int'(coin_reject), int'(m_rej));
        chk("model vend_req",    int'(vend_req),    int'(m_vending));
        chk("model change_req",  int'(change_req),  int'(m_refunding && (m_owed > 0)));
        chk("model credit",      int'(credit),      m_credit);
        chk("model change_left", int'(change_left), m_owed);
        chk("model busy",        int'(busy),        int'(m_vending || m_refunding));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic coin(input logic [1:0] c);
        coin_valid = 1'b1;
        coins      = c;
        tick();
        coin_valid = 1'b0;
        coins      = 2'b00;
    endtask

    task automatic drain();
        bit done;
        done = 0;
        vend_ack   = 1'b1;
        change_ack = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (!busy) begin
                done = 1;
                break;
            end
        end
        vend_ack   = 1'b0;
        change_ack = 1'b0;
        chk("drain to idle", int'(done), 1);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " coin_ready"},  int'(coin_ready),  1);
        chk({tag, " coin_reject"}, int'(coin_reject), 0);
        chk({tag, " vend_req"},    int'(vend_req),    0);
        chk({tag, " change_req"},  int'(change_req),  0);
        chk({tag, " credit"},      int'(credit),      0);
        chk({tag, " change_left"}, int'(change_left), 0);
        chk({tag, " busy"},        int'(busy),        0);
    endtask

    initial begin
        #12;
        chk_reset_vals("reset");
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // nickel then dime: credit 1, then 3, no vend
        coin(2'b01);
        chk("n credit", int'(credit), 1);
        chk("n vend_req", int'(vend_req), 0);
        coin(2'b10);
        chk("nd credit", int'(credit), 3);
        chk("nd vend_req", int'(vend_req), 0);
        cancel = 1'b1; tick(); cancel = 1'b0;
        chk("cancel change_left", int'(change_left), 3);
        drain();

        // dime, dime: exact price
        coin(2'b10);
        coin(2'b10);
        chk("dd vend_req", int'(vend_req), 1);
        chk("dd change_left", int'(change_left), 0);
        chk("dd credit", int'(credit), 0);
        tick(); tick(); tick();
        chk("dd vend_req held", int'(vend_req), 1);
        vend_ack = 1'b1; tick(); vend_ack = 1'b0;
        chk("dd vend_req drop", int'(vend_req), 0);
        chk("dd idle", int'(busy), 0);

        // dime, quarter: 3 nickels change with stalled acks
        coin(2'b10);
        coin(2'b11);
        chk("dq vend_req", int'(vend_req), 1);
        chk("dq change_left", int'(change_left), 3);
        vend_ack = 1'b1; tick(); vend_ack = 1'b0;
        chk("dq vend_req drop", int'(vend_req), 0);
        chk("dq change_req", int'(change_req), 1);
        for (int i = 0; i < 3; i++) begin
            change_ack = 1'b1; tick(); change_ack = 1'b0;
            chk("dq change_left step", int'(change_left), 2 - i);
            if (i < 2) begin
                tick(); tick();
                chk("dq change_req stall", int'(change_req), 1);
                chk("dq change_left stall", int'(change_left), 2 - i);
            end
        end
        chk("dq change_req end", int'(change_req), 0);
        chk("dq idle", int'(busy), 0);
        chk("dq credit", int'(credit), 0);

        // nickel, cancel, coin during CHANGE
        coin(2'b01);
        cancel = 1'b1; tick(); cancel = 1'b0;
        chk("nc change_left", int'(change_left), 1);
        chk("nc change_req", int'(change_req), 1);
        coin(2'b10);
        chk("nc coin_reject", int'(coin_reject), 1);
        chk("nc credit", int'(credit), 0);
        tick();
        chk("nc coin_reject pulse", int'(coin_reject), 0);
        change_ack = 1'b1; tick(); change_ack = 1'b0;
        chk("nc idle", int'(busy), 0);

        // code 00 rejected in IDLE
        coin(2'b00);
        chk("c00 coin_reject", int'(coin_reject), 1);
        chk("c00 credit", int'(credit), 0);

        // quarter with cancel in IDLE: full refund, no vend
        coin_valid = 1'b1; coins = 2'b11; cancel = 1'b1;
        tick();
        coin_valid = 1'b0; coins = 2'b00; cancel = 1'b0;
        chk("qc vend_req", int'(vend_req), 0);
        chk("qc change_left", int'(change_left), 5);
        chk("qc change_req", int'(change_req), 1);
        drain();

`ifdef VEND_TIMEOUT_EN
        coin(2'b01);
        for (int i = 0; i < 7; i++) tick();
        chk("tmo before credit", int'(credit), 1);
        chk("tmo before busy", int'(busy), 0);
        tick();
        chk("tmo change_req", int'(change_req), 1);
        chk("tmo change_left", int'(change_left), 1);
        drain();
`else
        coin(2'b01);
        for (int i = 0; i < 20; i++) tick();
        chk("hold credit", int'(credit), 1);
        chk("hold busy", int'(busy), 0);
        cancel = 1'b1; tick(); cancel = 1'b0;
        drain();
`endif

        // quarter, quarter during VEND, then async reset mid-VEND
        coin(2'b11);
        chk("qv vend_req", int'(vend_req), 1);
        chk("qv change_left", int'(change_left), 1);
        coin(2'b11);
        chk("qv coin_reject", int'(coin_reject), 1);
        chk("qv change_left kept", int'(change_left), 1);
        #3 rst_n = 1'b0;
        #1 chk_reset_vals("async reset");
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        for (int n = 0; n < 3000; n++) begin
            coin_valid = ($urandom_range(0, 99) < 30);
            coins      = 2'($urandom_range(0, 3));
            cancel     = ($urandom_range(0, 99) < 8);
            vend_ack   = ($urandom_range(0, 99) < 35);
            change_ack = ($urandom_range(0, 99) < 45);
            tick();
        end
        coin_valid = 1'b0; cancel = 1'b0; vend_ack = 1'b0; change_ack = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
